// File: rtl/result_streamer_if.sv
`timescale 1ns/1ps
// Memory read port and output stream of the result streamer, bundled for port hookup.
// The master side is the streamer; the slave side is the memory and the stream sink.
interface result_streamer_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 34
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_read_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;

  modport master (
    output mem_req, mem_address, m_valid, m_data, m_last,
    input  mem_read_data, m_ready
  );

  modport slave (
    input  mem_req, mem_address, m_valid, m_data, m_last,
    output mem_read_data, m_ready
  );
endinterface

// File: rtl/result_streamer.sv
`timescale 1ns/1ps
// Streams NUM_WORDS result words from the accelerator memory starting at BASE_ADDR,
// using a two-entry prefetch buffer fed by credit-limited synchronous reads.
module result_streamer #(
  parameter int                ADDR_W    = 7,
  parameter int                DATA_W    = 34,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 7'd96,
  parameter int                NUM_WORDS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                trigger,
  result_streamer_if.master   bus,
  output logic                busy,
  output logic                overrun
);
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
  logic              inflight_q, inflight_d;
  logic              inflight_last_q, inflight_last_d;
  logic [1:0]        count_q, count_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic              overrun_q, overrun_d;
  logic [DATA_W-1:0] buf_data_q [2];
  logic              buf_last_q [2];

  logic       valid;
  logic       pop;
  logic       push;
  logic       issue;
  logic       last_issue;
  logic [2:0] credit_used;

  assign valid = (count_q != 2'd0);
  assign pop   = valid && bus.m_ready;
  assign push  = inflight_q;
  // A slot freed by this cycle's pop counts as free, so one word per cycle is sustained.
  assign credit_used = 3'(count_q) + 3'(inflight_q) - 3'(pop);
  assign issue       = (state_q == RUN) && (credit_used < 3'd2);
  assign last_issue  = issue && (issue_cnt_q == LAST_IDX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (trigger) state_d = RUN;
      RUN:     if (last_issue) state_d = DRAIN;
      DRAIN:   if (!inflight_q && ((count_q == 2'd0) || (count_q == 2'd1 && pop))) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q != IDLE);
    bus.mem_req = issue;
    overrun_d   = trigger && (state_q != IDLE);
  end

  always_comb begin
    addr_d      = addr_q;
    issue_cnt_d = issue_cnt_q;
    if (state_q == IDLE && trigger) begin
      addr_d      = BASE_ADDR;
      issue_cnt_d = '0;
    end else if (issue) begin
      addr_d      = addr_q + ADDR_W'(1);
      issue_cnt_d = issue_cnt_q + CNT_W'(1);
    end
    inflight_d      = issue;
    inflight_last_d = last_issue;
    count_d         = count_q + 2'(push) - 2'(pop);
    wr_ptr_d        = wr_ptr_q ^ push;
    rd_ptr_d        = rd_ptr_q ^ pop;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q          <= '0;
      issue_cnt_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      count_q         <= 2'd0;
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      addr_q          <= addr_d;
      issue_cnt_q     <= issue_cnt_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      count_q         <= count_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      overrun_q       <= overrun_d;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    logic [DATA_W-1:0] data_d;
    logic              last_d;

    always_comb begin
      data_d = buf_data_q[gi];
      last_d = buf_last_q[gi];
      if (push && (wr_ptr_q == 1'(gi))) begin
        data_d = bus.mem_read_data;
        last_d = inflight_last_q;
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        buf_data_q[gi] <= '0;
        buf_last_q[gi] <= 1'b0;
      end else begin
        buf_data_q[gi] <= data_d;
        buf_last_q[gi] <= last_d;
      end
    end
  end

  assign bus.mem_address = addr_q;
  assign bus.m_valid     = valid;
  assign bus.m_data      = buf_data_q[rd_ptr_q];
  assign bus.m_last      = valid && buf_last_q[rd_ptr_q];
  assign overrun         = overrun_q;
endmodule
